// File: rtl/zcore_axil_pkg.sv
// Shared AXI-Lite definitions: response codes and axil_gpio register map.
package zcore_axil_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    localparam logic [7:0] GPIO_DATA_LO = 8'h00;
    localparam logic [7:0] GPIO_DATA_HI = 8'h04;
    localparam logic [7:0] GPIO_DIR_LO  = 8'h08;
    localparam logic [7:0] GPIO_DIR_HI  = 8'h0C;

    // EXOKAY is not an AXI-Lite code, so anything but OKAY counts as a failure.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/axil_gpio_wr_seq.sv
// Command-driven AXI-Lite write sequencer for bit-banging axil_gpio pins:
// one write per command, wait for B, then idle for the command's delay.
module axil_gpio_wr_seq
    import zcore_axil_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int STRB_WIDTH  = DATA_WIDTH / 8,
    parameter int DELAY_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [ADDR_WIDTH-1:0]  cmd_addr,
    input  logic [DATA_WIDTH-1:0]  cmd_data,
    input  logic [STRB_WIDTH-1:0]  cmd_strb,
    input  logic [DELAY_WIDTH-1:0] cmd_delay,

    output logic [ADDR_WIDTH-1:0]  m_axil_awaddr,
    output logic [2:0]             m_axil_awprot,
    output logic                   m_axil_awvalid,
    input  logic                   m_axil_awready,
    output logic [DATA_WIDTH-1:0]  m_axil_wdata,
    output logic [STRB_WIDTH-1:0]  m_axil_wstrb,
    output logic                   m_axil_wvalid,
    input  logic                   m_axil_wready,
    input  logic [1:0]             m_axil_bresp,
    input  logic                   m_axil_bvalid,
    output logic                   m_axil_bready,

    output logic                   busy,
    output logic                   err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_RESP = 2'd2,
        ST_WAIT = 2'd3
    } state_t;

    state_t                 state;
    logic                   aw_done;
    logic                   w_done;
    logic [DELAY_WIDTH-1:0] delay_q;
    logic [DELAY_WIDTH-1:0] count;

    logic aw_hs;
    logic w_hs;
    logic aw_fin;
    logic w_fin;

    assign aw_hs  = m_axil_awvalid & m_axil_awready;
    assign w_hs   = m_axil_wvalid & m_axil_wready;
    assign aw_fin = aw_done | aw_hs;
    assign w_fin  = w_done | w_hs;

    assign m_axil_awprot = 3'b000;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_IDLE;
            cmd_ready      <= 1'b1;
            busy           <= 1'b0;
            err            <= 1'b0;
            m_axil_awvalid <= 1'b0;
            m_axil_wvalid  <= 1'b0;
            m_axil_bready  <= 1'b0;
            m_axil_awaddr  <= '0;
            m_axil_wdata   <= '0;
            m_axil_wstrb   <= '0;
            delay_q        <= '0;
            count          <= '0;
            aw_done        <= 1'b0;
            w_done         <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        m_axil_awaddr  <= cmd_addr;
                        m_axil_wdata   <= cmd_data;
                        m_axil_wstrb   <= cmd_strb;
                        delay_q        <= cmd_delay;
                        m_axil_awvalid <= 1'b1;
                        m_axil_wvalid  <= 1'b1;
                        aw_done        <= 1'b0;
                        w_done         <= 1'b0;
                        cmd_ready      <= 1'b0;
                        busy           <= 1'b1;
                        state          <= ST_SEND;
                    end
                end

                // AW and W complete independently; B is only opened once both have.
                ST_SEND: begin
                    if (aw_hs) m_axil_awvalid <= 1'b0;
                    if (w_hs)  m_axil_wvalid  <= 1'b0;
                    aw_done <= aw_fin;
                    w_done  <= w_fin;
                    if (aw_fin && w_fin) begin
                        m_axil_bready <= 1'b1;
                        state         <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    if (m_axil_bvalid) begin
                        m_axil_bready <= 1'b0;
                        err           <= resp_is_err(m_axil_bresp);
                        if (delay_q == '0) begin
                            cmd_ready <= 1'b1;
                            busy      <= 1'b0;
                            state     <= ST_IDLE;
                        end else begin
                            count <= delay_q;
                            state <= ST_WAIT;
                        end
                    end
                end

                // Entered with count=delay, so exactly `delay` cycles are spent here.
                ST_WAIT: begin
                    if (count == DELAY_WIDTH'(1)) begin
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end else begin
                        count <= count - DELAY_WIDTH'(1);
                    end
                end

                default: begin
                    cmd_ready      <= 1'b1;
                    busy           <= 1'b0;
                    m_axil_awvalid <= 1'b0;
                    m_axil_wvalid  <= 1'b0;
                    m_axil_bready  <= 1'b0;
                    state          <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axil_gpio_wr_seq.sv
// Bench for axil_gpio_wr_seq: a cycle-driven slave with per-command latencies,
// a GPIO register model, and timing expectations derived from handshake rules.
module tb_axil_gpio_wr_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_data = '0;
    logic [3:0]  cmd_strb = '0;
    logic [15:0] cmd_delay = '0;
    logic [31:0] m_axil_awaddr;
    logic [2:0]  m_axil_awprot;
    logic        m_axil_awvalid;
    logic        m_axil_awready = 1'b0;
    logic [31:0] m_axil_wdata;
    logic [3:0]  m_axil_wstrb;
    logic        m_axil_wvalid;
    logic        m_axil_wready = 1'b0;
    logic [1:0]  m_axil_bresp = 2'b00;
    logic        m_axil_bvalid = 1'b0;
    logic        m_axil_bready;
    logic        busy;
    logic        err;

    int checks = 0;
    int failures = 0;

    // What the slave stored vs. what the command stream says it should hold.
    logic [31:0] sregs [4];
    logic [31:0] mregs [4];

    // Observations of the most recent run_cmd.
    int          r_aw_cnt, r_w_cnt, r_b_cnt, r_err_cnt;
    int          r_b_c, r_ready_c, r_busy_wait, r_awv_cyc, r_wv_cyc;
    logic        r_busy_at_ready, r_timeout;
    logic [31:0] r_awaddr, r_wdata;
    logic [3:0]  r_wstrb;

    axil_gpio_wr_seq #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .STRB_WIDTH(4), .DELAY_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_data(cmd_data), .cmd_strb(cmd_strb), .cmd_delay(cmd_delay),
        .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
        .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
        .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
        .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
        .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid),
        .m_axil_bready(m_axil_bready), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    // Called at a negedge; returns at the negedge where cmd_ready is seen again.
    task automatic run_cmd(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [15:0] dl, input int awl, input int wl, input int bl,
                           input logic [1:0] br);
        int c;
        int both_c;
        bit aw_got, w_got;
        r_aw_cnt = 0; r_w_cnt = 0; r_b_cnt = 0; r_err_cnt = 0; r_b_c = -1; r_ready_c = -1;
        r_busy_wait = 0; r_awv_cyc = 0; r_wv_cyc = 0; r_timeout = 1'b0; r_busy_at_ready = 1'b1;
        aw_got = 0; w_got = 0; both_c = -1;
        cmd_valid = 1'b1; cmd_addr = a; cmd_data = d; cmd_strb = s; cmd_delay = dl;
        c = 0;
        while (!cmd_ready && c < 200) begin @(negedge clk); c++; end
        if (!cmd_ready) begin r_timeout = 1'b1; cmd_valid = 1'b0; return; end
        @(negedge clk);
        cmd_valid = 1'b0; cmd_addr = $urandom; cmd_data = $urandom;
        cmd_strb = 4'($urandom); cmd_delay = 16'($urandom);
        mregs[a[3:2]] = merge(mregs[a[3:2]], d, s);
        c = 1;
        while (c < 300) begin
            m_axil_awready = (c > awl);
            m_axil_wready  = (c > wl);
            m_axil_bvalid  = (both_c >= 0) && (c > both_c + bl) && (r_b_c < 0);
            m_axil_bresp   = m_axil_bvalid ? br : 2'b00;
            if (err) r_err_cnt++;
            if (m_axil_awvalid) r_awv_cyc++;
            if (m_axil_wvalid) r_wv_cyc++;
            if (r_b_c >= 0) begin
                if (cmd_ready) begin r_ready_c = c; r_busy_at_ready = busy; break; end
                if (busy) r_busy_wait++;
            end
            if (m_axil_awvalid && m_axil_awready) begin
                r_aw_cnt++; r_awaddr = m_axil_awaddr; aw_got = 1;
            end
            if (m_axil_wvalid && m_axil_wready) begin
                r_w_cnt++; r_wdata = m_axil_wdata; r_wstrb = m_axil_wstrb; w_got = 1;
            end
            if (m_axil_bvalid && m_axil_bready) begin
                r_b_cnt++; r_b_c = c;
                sregs[r_awaddr[3:2]] = merge(sregs[r_awaddr[3:2]], r_wdata, r_wstrb);
            end
            if (aw_got && w_got && both_c < 0) both_c = c;
            @(negedge clk);
            c++;
        end
        m_axil_awready = 1'b0; m_axil_wready = 1'b0; m_axil_bvalid = 1'b0; m_axil_bresp = 2'b00;
        if (r_ready_c < 0) r_timeout = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; cmd_valid = 1'b1; cmd_addr = 32'h8; cmd_data = 32'hFF; cmd_strb = 4'hF;
        m_axil_awready = 1'b1; m_axil_wready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
            checks++; if ({m_axil_awvalid, m_axil_wvalid, m_axil_bready} !== 3'b000) begin failures++; $display("FAIL reset_valids: got %b want 000", {m_axil_awvalid, m_axil_wvalid, m_axil_bready}); end
            checks++; if ({busy, err} !== 2'b00) begin failures++; $display("FAIL reset_busy_err: got %b want 00", {busy, err}); end
            checks++; if (m_axil_awaddr !== 32'h0 || m_axil_wdata !== 32'h0) begin failures++; $display("FAIL reset_regs: got %h/%h want 0/0", m_axil_awaddr, m_axil_wdata); end
        end
        checks++; if (m_axil_awprot !== 3'b000) begin failures++; $display("FAIL awprot: got %b want 000", m_axil_awprot); end
        cmd_valid = 1'b0; m_axil_awready = 1'b0; m_axil_wready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_gpio_write();
        logic [7:0] gpio;
        run_cmd(32'h08, 32'h000000FF, 4'hF, 16'd0, 0, 0, 0, 2'b00);
        checks++; if (r_timeout || r_aw_cnt != 1 || r_w_cnt != 1) begin failures++; $display("FAIL gpio_dir_hs: got aw=%0d w=%0d to=%b want 1 1 0", r_aw_cnt, r_w_cnt, r_timeout); end
        checks++; if (r_err_cnt != 0) begin failures++; $display("FAIL gpio_dir_err: got %0d want 0", r_err_cnt); end
        run_cmd(32'h00, 32'h000000A5, 4'hF, 16'd0, 0, 0, 0, 2'b00);
        checks++; if (r_timeout || r_aw_cnt != 1 || r_w_cnt != 1) begin failures++; $display("FAIL gpio_data_hs: got aw=%0d w=%0d to=%b want 1 1 0", r_aw_cnt, r_w_cnt, r_timeout); end
        checks++; if (r_err_cnt != 0) begin failures++; $display("FAIL gpio_data_err: got %0d want 0", r_err_cnt); end
        gpio = sregs[0][7:0] & sregs[2][7:0];
        checks++; if (gpio !== 8'hA5) begin failures++; $display("FAIL gpio_pins: got %h want a5", gpio); end
    endtask

    task automatic test_back_to_back();
        // Always-ready slave, delay 0: AW/W at T+1, B at T+2, ready again at T+3.
        for (int i = 0; i < 3; i++) begin
            run_cmd(32'h04, $urandom, 4'hF, 16'd0, 0, 0, 0, 2'b00);
            checks++; if (r_b_c != 2) begin failures++; $display("FAIL b2b_b_cycle: got %0d want 2", r_b_c); end
            checks++; if (r_ready_c != 3) begin failures++; $display("FAIL b2b_ready_cycle: got %0d want 3", r_ready_c); end
        end
    endtask

    task automatic test_skewed_ready();
        run_cmd(32'h0C, 32'h12345678, 4'h3, 16'd0, 3, 0, 0, 2'b00);
        checks++; if (r_wv_cyc != 1) begin failures++; $display("FAIL skew_wvalid_cycles: got %0d want 1", r_wv_cyc); end
        checks++; if (r_awv_cyc != 4) begin failures++; $display("FAIL skew_awvalid_cycles: got %0d want 4", r_awv_cyc); end
        checks++; if (r_b_cnt != 1 || r_aw_cnt != 1 || r_w_cnt != 1) begin failures++; $display("FAIL skew_hs_counts: got b=%0d aw=%0d w=%0d want 1 1 1", r_b_cnt, r_aw_cnt, r_w_cnt); end
        checks++; if (r_b_c != 5) begin failures++; $display("FAIL skew_b_cycle: got %0d want 5", r_b_c); end
    endtask

    task automatic test_delay();
        run_cmd(32'h00, 32'h0000005A, 4'h1, 16'd5, 0, 0, 0, 2'b00);
        checks++; if (r_busy_wait != 5) begin failures++; $display("FAIL delay_busy_cycles: got %0d want 5", r_busy_wait); end
        checks++; if (r_ready_c - r_b_c != 6) begin failures++; $display("FAIL delay_ready_gap: got %0d want 6", r_ready_c - r_b_c); end
        checks++; if (r_busy_at_ready !== 1'b0) begin failures++; $display("FAIL delay_busy_at_ready: got %b want 0", r_busy_at_ready); end
    endtask

    task automatic test_error();
        run_cmd(32'h08, 32'hFFFF0000, 4'hC, 16'd0, 1, 2, 1, 2'b10);
        checks++; if (r_err_cnt != 1) begin failures++; $display("FAIL err_pulse_cycles: got %0d want 1", r_err_cnt); end
        checks++; if (r_timeout) begin failures++; $display("FAIL err_return_idle: got timeout want ready"); end
        run_cmd(32'h04, 32'hCAFEF00D, 4'hF, 16'd2, 0, 1, 0, 2'b00);
        checks++; if (r_err_cnt != 0 || r_b_cnt != 1) begin failures++; $display("FAIL err_next_cmd: got err=%0d b=%0d want 0 1", r_err_cnt, r_b_cnt); end
        checks++; if (r_wdata !== 32'hCAFEF00D) begin failures++; $display("FAIL err_next_wdata: got %h want cafef00d", r_wdata); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a, d;
            logic [3:0] s;
            logic [15:0] dl;
            logic [1:0] br;
            int awl, wl, bl, exp_b;
            a = 32'($urandom_range(0, 3)) << 2; d = $urandom; s = 4'($urandom);
            dl = 16'($urandom_range(0, 7)); awl = $urandom_range(0, 3); wl = $urandom_range(0, 3);
            bl = $urandom_range(0, 3); br = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
            exp_b = ((awl > wl) ? awl : wl) + 2 + bl;
            run_cmd(a, d, s, dl, awl, wl, bl, br);
            checks++; if (r_timeout) begin failures++; $display("FAIL rnd%0d_timeout: got stuck want ready", n); end
            checks++; if (r_aw_cnt != 1 || r_w_cnt != 1 || r_b_cnt != 1) begin failures++; $display("FAIL rnd%0d_hs: got aw=%0d w=%0d b=%0d want 1 1 1", n, r_aw_cnt, r_w_cnt, r_b_cnt); end
            checks++; if (r_awaddr !== a || r_wdata !== d || r_wstrb !== s) begin failures++; $display("FAIL rnd%0d_payload: got %h/%h/%h want %h/%h/%h", n, r_awaddr, r_wdata, r_wstrb, a, d, s); end
            checks++; if (r_awv_cyc != awl + 1 || r_wv_cyc != wl + 1) begin failures++; $display("FAIL rnd%0d_valid_cycles: got %0d/%0d want %0d/%0d", n, r_awv_cyc, r_wv_cyc, awl + 1, wl + 1); end
            checks++; if (r_b_c != exp_b) begin failures++; $display("FAIL rnd%0d_b_cycle: got %0d want %0d", n, r_b_c, exp_b); end
            checks++; if (r_ready_c != exp_b + int'(dl) + 1 || r_busy_wait != int'(dl)) begin failures++; $display("FAIL rnd%0d_delay: got ready=%0d busy=%0d want %0d %0d", n, r_ready_c, r_busy_wait, exp_b + int'(dl) + 1, dl); end
            checks++; if (r_err_cnt != ((br != 2'b00) ? 1 : 0)) begin failures++; $display("FAIL rnd%0d_err: got %0d want %0d", n, r_err_cnt, (br != 2'b00) ? 1 : 0); end
        end
        for (int i = 0; i < 4; i++) begin
            checks++; if (sregs[i] !== mregs[i]) begin failures++; $display("FAIL rnd_reg%0d: got %h want %h", i, sregs[i], mregs[i]); end
        end
    endtask

    task automatic test_reset_mid_send();
        cmd_valid = 1'b1; cmd_addr = 32'h00; cmd_data = 32'hDEADBEEF; cmd_strb = 4'hF; cmd_delay = 16'd0;
        m_axil_awready = 1'b0; m_axil_wready = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++; if (m_axil_awvalid !== 1'b1 || m_axil_wvalid !== 1'b1) begin failures++; $display("FAIL midrst_pre_valids: got %b%b want 11", m_axil_awvalid, m_axil_wvalid); end
        #2 rst = 1'b0;
        #1;
        checks++; if (m_axil_awvalid !== 1'b0 || m_axil_wvalid !== 1'b0) begin failures++; $display("FAIL midrst_async_drop: got %b%b want 00", m_axil_awvalid, m_axil_wvalid); end
        checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL midrst_async_idle: got ready=%b busy=%b want 1 0", cmd_ready, busy); end
        @(negedge clk);
        rst = 1'b1;
        m_axil_awready = 1'b1; m_axil_wready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || m_axil_awvalid !== 1'b0 || m_axil_wvalid !== 1'b0) begin failures++; $display("FAIL midrst_after_release: got ready=%b busy=%b aw=%b w=%b want 1 0 0 0", cmd_ready, busy, m_axil_awvalid, m_axil_wvalid); end
        end
        m_axil_awready = 1'b0; m_axil_wready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin sregs[i] = '0; mregs[i] = '0; end
        test_reset();
        test_gpio_write();
        test_back_to_back();
        test_skewed_ready();
        test_delay();
        test_error();
        test_random();
        test_reset_mid_send();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
